// File: rtl/sys_cmd_pkg.sv
// Shared opcodes, command/state types and per-type frame/response lengths
// for the host-side UART command initiator.
package sys_cmd_pkg;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   typedef enum logic [1:0] {
      RF_WR   = 2'd0,
      RF_RD   = 2'd1,
      ALU_OP  = 2'd2,
      ALU_NOP = 2'd3
   } cmd_type_t;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_RSP
   } state_t;

   localparam int FRAME_LEN_RF_WR   = 3;
   localparam int FRAME_LEN_RF_RD   = 2;
   localparam int FRAME_LEN_ALU_OP  = 4;
   localparam int FRAME_LEN_ALU_NOP = 2;

   localparam int RSP_LEN_RF_WR   = 0;
   localparam int RSP_LEN_RF_RD   = 1;
   localparam int RSP_LEN_ALU_OP  = 2;
   localparam int RSP_LEN_ALU_NOP = 2;

   function automatic logic [2:0] frame_len(input cmd_type_t t);
      case (t)
         RF_WR:   return 3'(FRAME_LEN_RF_WR);
         RF_RD:   return 3'(FRAME_LEN_RF_RD);
         ALU_OP:  return 3'(FRAME_LEN_ALU_OP);
         default: return 3'(FRAME_LEN_ALU_NOP);
      endcase
   endfunction

   function automatic logic [1:0] rsp_len(input cmd_type_t t);
      case (t)
         RF_WR:   return 2'(RSP_LEN_RF_WR);
         RF_RD:   return 2'(RSP_LEN_RF_RD);
         ALU_OP:  return 2'(RSP_LEN_ALU_OP);
         default: return 2'(RSP_LEN_ALU_NOP);
      endcase
   endfunction

endpackage

// File: rtl/sys_cmd_timer.sv
// Response watchdog: counts enabled cycles, restarts on clr, and pulses expire
// combinationally on the cycle the count reaches TIMEOUT.
module sys_cmd_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   // A clear on the expiry cycle wins, so an arriving byte always restarts the wait.
   assign expire = en && !clr && (cnt == LAST);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)              cnt <= '0;
      else if (clr || expire) cnt <= '0;
      else if (en)           cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/sys_cmd_master.sv
// Host-side UART command initiator: serializes one command frame to the UART TX
// and assembles the response bytes. Optional watchdog under SYS_CMD_TIMEOUT_EN.
module sys_cmd_master
   import sys_cmd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR       = 4,
   parameter int OUT_WIDTH  = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CMD_VLD,
   output logic                  CMD_RDY,
   input  logic [1:0]            CMD_TYPE,
   input  logic [ADDR-1:0]       CMD_ADDR,
   input  logic [DATA_WIDTH-1:0] CMD_WRDATA,
   input  logic [DATA_WIDTH-1:0] CMD_OP_A,
   input  logic [DATA_WIDTH-1:0] CMD_OP_B,
   input  logic [3:0]            CMD_FUN,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   input  logic                  TX_BUSY,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic [OUT_WIDTH-1:0]  RSP_DATA,
   output logic                  RSP_VLD,
   output logic                  RSP_TIMEOUT,
   output logic                  BUSY
);

   if (OUT_WIDTH != 2 * DATA_WIDTH || TIMEOUT < 1 || ADDR > DATA_WIDTH) begin : g_cfg_check
      $error("sys_cmd_master: inconsistent parameters");
   end

   state_t                          state;
   cmd_type_t                       ctype;
   logic [3:0][DATA_WIDTH-1:0]      frame, frame_in;
   logic [1:0]                      idx;
   logic [1:0]                      rsp_cnt;
   logic [DATA_WIDTH-1:0]           b0;
   logic                            tmr_expire;

   assign CMD_RDY = (state == IDLE);
   assign BUSY    = (state != IDLE);

`ifdef SYS_CMD_TIMEOUT_EN
   sys_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .CLK    (CLK),
      .RST    (RST),
      .clr    ((state != WAIT_RSP) || RX_D_VLD),
      .en     (state == WAIT_RSP),
      .expire (tmr_expire)
   );
`else
   assign tmr_expire = 1'b0;
`endif

   always_comb begin
      frame_in = '0;
      case (cmd_type_t'(CMD_TYPE))
         RF_WR: begin
            frame_in[0] = DATA_WIDTH'(CMD_RF_WR);
            frame_in[1] = DATA_WIDTH'(CMD_ADDR);
            frame_in[2] = CMD_WRDATA;
         end
         RF_RD: begin
            frame_in[0] = DATA_WIDTH'(CMD_RF_RD);
            frame_in[1] = DATA_WIDTH'(CMD_ADDR);
         end
         ALU_OP: begin
            frame_in[0] = DATA_WIDTH'(CMD_ALU_OP);
            frame_in[1] = CMD_OP_A;
            frame_in[2] = CMD_OP_B;
            frame_in[3] = DATA_WIDTH'(CMD_FUN);
         end
         default: begin
            frame_in[0] = DATA_WIDTH'(CMD_ALU_NOP);
            frame_in[1] = DATA_WIDTH'(CMD_FUN);
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         ctype       <= RF_WR;
         frame       <= '0;
         idx         <= '0;
         rsp_cnt     <= '0;
         b0          <= '0;
         TX_P_DATA   <= '0;
         TX_D_VLD    <= 1'b0;
         RSP_DATA    <= '0;
         RSP_VLD     <= 1'b0;
         RSP_TIMEOUT <= 1'b0;
      end else begin
         RSP_VLD     <= 1'b0;
         RSP_TIMEOUT <= 1'b0;
         case (state)
            IDLE: begin
               if (CMD_VLD) begin
                  ctype     <= cmd_type_t'(CMD_TYPE);
                  frame     <= frame_in;
                  TX_P_DATA <= frame_in[0];
                  TX_D_VLD  <= 1'b1;
                  idx       <= '0;
                  state     <= SEND;
               end
            end
            // RX bytes seen here are stray: the responder cannot answer mid-frame.
            SEND: begin
               if (TX_D_VLD && !TX_BUSY) begin
                  if ({1'b0, idx} + 3'd1 == frame_len(ctype)) begin
                     TX_D_VLD <= 1'b0;
                     rsp_cnt  <= '0;
                     if (rsp_len(ctype) == 2'd0) begin
                        RSP_DATA <= '0;
                        RSP_VLD  <= 1'b1;
                        state    <= IDLE;
                     end else begin
                        state    <= WAIT_RSP;
                     end
                  end else begin
                     idx       <= idx + 2'd1;
                     TX_P_DATA <= frame[idx + 2'd1];
                  end
               end
            end
            WAIT_RSP: begin
               if (RX_D_VLD) begin
                  if (rsp_cnt + 2'd1 == rsp_len(ctype)) begin
                     RSP_DATA <= (ctype == RF_RD) ? OUT_WIDTH'(RX_P_DATA)
                                                  : OUT_WIDTH'({RX_P_DATA, b0});
                     RSP_VLD  <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     b0      <= RX_P_DATA;
                     rsp_cnt <= rsp_cnt + 2'd1;
                  end
               end else if (tmr_expire) begin
                  RSP_TIMEOUT <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
